// File: rtl/loop_accum_sequencer.sv
// ============================================================================
// Module  : loop_accum_sequencer
// Purpose : Counted-loop power-of-two accumulator with a valid/ready command
//           port and a valid/ready result port. The first loop iteration
//           clears the accumulator, later ones add 2**idx, then one doubling.
// Config  : LOOP_ACCUM_SAT_EN - saturating add/double instead of wrap-around
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module loop_accum_sequencer #(
    parameter int W  = 16,
    parameter int IW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [IW-1:0] lo,
    input  logic [IW-1:0] hi,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  res,
    output logic          busy,
    output logic [IW-1:0] idx_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOOP  = 2'd1,
        S_SCALE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  res_q, res_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] lo_q, lo_d;
    logic [IW-1:0] hi_q, hi_d;

    logic [W-1:0]  term;
    logic [W-1:0]  add_val;
    logic [W-1:0]  dbl_val;

    // Indices at or above the accumulator width contribute nothing.
    always_comb begin
        term = '0;
        if (int'(idx_q) < W) begin
            term = {{(W-1){1'b0}}, 1'b1} << idx_q;
        end
    end

`ifdef LOOP_ACCUM_SAT_EN
    logic [W:0] sum;

    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, term};
        add_val = sum[W] ? {W{1'b1}} : sum[W-1:0];
        dbl_val = acc_q[W-1] ? {W{1'b1}} : {acc_q[W-2:0], 1'b0};
    end
`else
    always_comb begin
        add_val = acc_q + term;
        dbl_val = {acc_q[W-2:0], 1'b0};
    end
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        res_d       = res_q;
        idx_d       = idx_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        start_ready = 1'b0;
        res_valid   = 1'b0;

        case (state_q)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    lo_d  = lo;
                    hi_d  = hi;
                    idx_d = lo;
                    if (lo < hi) begin
                        state_d = S_LOOP;
                    end else begin
                        acc_d   = '0;
                        state_d = S_SCALE;
                    end
                end
            end
            S_LOOP: begin
                acc_d = (idx_q == lo_q) ? '0 : add_val;
                // hi_q > idx_q here, so the increment cannot wrap.
                idx_d = idx_q + 1'b1;
                if (idx_q == hi_q - 1'b1) begin
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                acc_d   = dbl_val;
                res_d   = dbl_val;
                state_d = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    assign res   = res_q;
    assign busy  = (state_q != S_IDLE);
    assign idx_o = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_loop_accum_sequencer.sv
// ============================================================================
// Module  : tb_loop_accum_sequencer
// Purpose : Randomized self-checking bench for loop_accum_sequencer against a
//           plain-arithmetic reference model (honours LOOP_ACCUM_SAT_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_loop_accum_sequencer;

    localparam int W  = 16;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [IW-1:0] lo = '0;
    logic [IW-1:0] hi = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  res;
    logic          busy;
    logic [IW-1:0] idx_o;

    int checks = 0;
    int errors = 0;

    loop_accum_sequencer #(.W(W), .IW(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .lo         (lo),
        .hi         (hi),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res        (res),
        .busy       (busy),
        .idx_o      (idx_o)
    );

    always #5 clk = ~clk;

    // Sum of 2**i for i in (lo, hi) below W, then doubled, in wide arithmetic.
    function automatic logic [W-1:0] model(input int l, input int h);
        longint acc;
        longint maxv;
        logic [63:0] r;
        acc  = 0;
        maxv = (longint'(1) << W) - 1;
        for (int i = l + 1; i < h; i++) begin
            if (i < W) acc += (longint'(1) << i);
        end
`ifdef LOOP_ACCUM_SAT_EN
        if (acc > maxv) acc = maxv;
        acc = acc * 2;
        if (acc > maxv) acc = maxv;
`else
        acc = (acc * 2) & maxv;
`endif
        r = 64'(acc);
        return r[W-1:0];
    endfunction

    task automatic run_cmd(input int l, input int h, input int stall, output logic [W-1:0] got);
        int n;
        int edges;
        logic [W-1:0] exp;
        logic [IW-1:0] lv;
        n   = (l < h) ? (h - l) : 0;
        exp = model(l, h);
        lv  = IW'(l);
        start_valid = 1'b1;
        lo = IW'(l);
        hi = IW'(h);
        res_ready = 1'b0;
        checks++;
        if (start_ready !== 1'b1) begin
            errors++; $display("FAIL cmd_ready lo=%0d hi=%0d got %b want 1", l, h, start_ready);
        end
        @(posedge clk); #1;
        start_valid = 1'b0;
        lo = IW'($urandom);
        hi = IW'($urandom);
        checks++;
        if (busy !== 1'b1 || idx_o !== lv || start_ready !== 1'b0) begin
            errors++;
            $display("FAIL accept_state lo=%0d hi=%0d busy=%b idx_o=%0d start_ready=%b want 1 %0d 0",
                     l, h, busy, idx_o, start_ready, lv);
        end
        edges = 0;
        while (res_valid !== 1'b1 && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        checks++;
        if (edges + 1 != n + 2) begin
            errors++; $display("FAIL latency lo=%0d hi=%0d got %0d edges want %0d", l, h, edges + 1, n + 2);
        end
        checks++;
        if (res !== exp) begin
            errors++; $display("FAIL result lo=%0d hi=%0d got %h want %h", l, h, res, exp);
        end
        got = res;
        for (int s = 0; s < stall; s++) begin
            start_valid = 1'($urandom_range(0, 1));
            lo = IW'($urandom);
            hi = IW'($urandom);
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b1 || res !== exp || start_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold lo=%0d hi=%0d valid=%b res=%h ready=%b want 1 %h 0",
                         l, h, res_valid, res, start_ready, exp);
            end
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL handshake lo=%0d hi=%0d valid=%b ready=%b busy=%b want 0 1 0",
                     l, h, res_valid, start_ready, busy);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0 || res !== '0 || busy !== 1'b0 || idx_o !== '0) begin
            errors++;
            $display("FAIL reset_values ready=%b valid=%b res=%h busy=%b idx=%0d want 1 0 0 0 0",
                     start_ready, res_valid, res, busy, idx_o);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] got;
        run_cmd(5, 10, 0, got);
        checks++;
        if (got !== 16'h0780) begin
            errors++; $display("FAIL basic_5_10 got %h want 0780", got);
        end
    endtask

    task automatic test_empty();
        logic [W-1:0] got;
        run_cmd(7, 7, 0, got);
        checks++;
        if (got !== '0) begin errors++; $display("FAIL empty_7_7 got %h want 0", got); end
        run_cmd(9, 3, 1, got);
        checks++;
        if (got !== '0) begin errors++; $display("FAIL empty_9_3 got %h want 0", got); end
    endtask

    task automatic test_wide();
        logic [W-1:0] got;
        logic [W-1:0] want;
`ifdef LOOP_ACCUM_SAT_EN
        want = 16'hFFFF;
`else
        want = 16'hFFFC;
`endif
        run_cmd(0, 31, 0, got);
        checks++;
        if (got !== want) begin errors++; $display("FAIL wide_0_31 got %h want %h", got, want); end
    endtask

    task automatic test_stall();
        logic [W-1:0] got;
        run_cmd(3, 5, 10, got);
        checks++;
        if (got !== 16'd32) begin errors++; $display("FAIL stall_3_5 got %h want 0020", got); end
        run_cmd(1, 4, 0, got);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] got;
        start_valid = 1'b1;
        lo = 5'd2;
        hi = 5'd12;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || idx_o !== 5'd6) begin
            errors++; $display("FAIL mid_loop busy=%b idx=%0d want 1 6", busy, idx_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0 || res !== '0 || busy !== 1'b0 || idx_o !== '0) begin
            errors++;
            $display("FAIL async_reset ready=%b valid=%b res=%h busy=%b idx=%0d want 1 0 0 0 0",
                     start_ready, res_valid, res, busy, idx_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_cmd(5, 6, 0, got);
        checks++;
        if (got !== '0) begin errors++; $display("FAIL after_reset_5_6 got %h want 0", got); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got;
        int l;
        int h;
        for (int k = 0; k < 25; k++) begin
            l = int'($urandom_range(0, 31));
            h = int'($urandom_range(0, 31));
            run_cmd(l, h, int'($urandom_range(0, 3)), got);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_empty();
        test_wide();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
